v_store_drain: RTL and testbench
================================

Name: v_store_drain

Overview:
- Write-drain buffer directly downstream of the vector store unit.
- Captures the up-to-4 bank writes (address + data per bank) that the store unit issues each cycle into four per-bank FIFOs.
- Drains each FIFO independently into its data-memory bank under a per-bank ready.
- Signals store completion only once every write of the instruction has actually reached memory.

Parameters:
- DEPTH, 4, entries per bank FIFO (power of two, ≥2).
- AW, `DATAMEM_BITS, bank address width.
- DW, `DATAMEM_WIDTH, bank data width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  store unit presents a write group this cycle.
- in_ready  output  1  group accepted when in_valid && in_ready.
- in_we  input  4  bit k = bank k carries a write in this group.
- in_last  input  1  group is the final one of the store instruction (store unit done).
- in_addr0..in_addr3  input  AW each  bank k word address.
- in_data0..in_data3  input  DW each  bank k write data.
- mem_we0..mem_we3  output  1 each  bank k write request (FIFO k non-empty).
- mem_addr0..mem_addr3  output  AW each  head-entry address, bank k.
- mem_data0..mem_data3  output  DW each  head-entry data, bank k.
- mem_ready0..mem_ready3  input  1 each  bank k accepts the write this cycle.
- busy  output  1  any FIFO non-empty or a last-group completion pending.
- store_done  output  1  one-cycle pulse: the last group fully written to memory.

Behaviour:
- Reset (rst high at a clock edge):
  - All FIFO pointers and counts go to 0, and all entries are discarded.
  - mem_we* = 0, busy = 0, store_done = 0, last_pending = 0.
  - in_ready is 0 while rst is high.
  - Reset mid-drain drops outstanding writes and produces no store_done.
- Accept:
  - in_ready = !rst && every FIFO count < DEPTH.
  - in_ready is conservative: it depends on all four banks regardless of in_we.
  - It is computed from the registered counts only; a same-cycle pop does not free a slot (no bypass).
- Push: on accept, for each k with in_we[k]=1, {in_addr_k, in_data_k} is written at the FIFO k tail. Banks with in_we[k]=0 are untouched.
- An accepted group with in_we=0000 pushes nothing. Its in_last is still honoured.
- Drain:
  - mem_we_k = (count_k != 0). mem_addr_k and mem_data_k come from the head entry.
  - Pop when mem_we_k && mem_ready_k. Outputs hold stable while mem_ready_k is low.
- Latency: a group accepted at edge N is presented on mem_* during cycle N+1 at the earliest.
- Per-bank order is strict FIFO. Banks drain independently with no cross-bank ordering.
- Simultaneous push and pop on a bank: count unchanged, and both pointers advance modulo DEPTH (wrap-around).
- Completion:
  - last_pending sets when a group with in_last=1 is accepted.
  - While last_pending=1, in_ready=0. No new instruction is accepted until completion.
  - When last_pending=1 and all counts are 0 (registered), store_done pulses high for exactly one cycle and last_pending clears on that edge.
  - in_last with in_we=0000 accepted while empty → store_done on the following cycle.
- busy = last_pending || any count != 0.
- Counts are $clog2(DEPTH)+1 bits wide. Overflow and underflow cannot occur by construction; verification asserts this.

Test Plan:
- Single VSE32 group: in_we=1111, in_addr0..3=0,1,2,3, data 0x00000000/0x11111111/0x22222222/0x33333333, in_last=1, all mem_ready=1 → one cycle later all mem_we=1 with those values; next cycle store_done=1 for one cycle; busy falls after the pulse.
- LMUL=2 stream: 2 groups (0x0..0x33.. then 0x44..0x77..), last on the second, mem_ready=1 → each bank writes 2 entries in order; store_done asserts exactly once, after the second write.
- Backpressure on one bank: mem_ready2=0 while 5 groups are offered → after 4 accepts in_ready=0 (FIFO2 full); banks 0, 1 and 3 drain. Releasing mem_ready2 lets FIFO2 drain in order, with the 5th group accepted one cycle after FIFO2 drops below DEPTH. Pointers wrap correctly.
- Sparse enables (strided store): in_we=0101 then 1010 → only banks 0,2 then 1,3 get mem_we; other banks stay idle; store_done follows the final drain.
- Reset mid-operation: assert rst with 3 entries queued and last_pending=1 → next cycle all mem_we=0, busy=0, no store_done; after rst falls, in_ready=1 and a fresh group completes normally.
- Empty last group: in_we=0000, in_last=1 while idle → store_done pulses on the next cycle; no mem_we asserted.

Source files
------------

// File: rtl/v_store_drain.sv
// Write-drain buffer: four per-bank FIFOs between the vector store unit and the data-memory banks.
// Head entry is on mem_* one cycle after accept; in_ready drops if any bank is full or a completion is pending.
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 10
`endif
`ifndef DATAMEM_WIDTH
`define DATAMEM_WIDTH 32
`endif

module v_store_drain #(
  parameter int DEPTH = 4,
  parameter int AW    = `DATAMEM_BITS,
  parameter int DW    = `DATAMEM_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_we,
  input  logic          in_last,
  input  logic [AW-1:0] in_addr0,
  input  logic [AW-1:0] in_addr1,
  input  logic [AW-1:0] in_addr2,
  input  logic [AW-1:0] in_addr3,
  input  logic [DW-1:0] in_data0,
  input  logic [DW-1:0] in_data1,
  input  logic [DW-1:0] in_data2,
  input  logic [DW-1:0] in_data3,
  output logic          mem_we0,
  output logic          mem_we1,
  output logic          mem_we2,
  output logic          mem_we3,
  output logic [AW-1:0] mem_addr0,
  output logic [AW-1:0] mem_addr1,
  output logic [AW-1:0] mem_addr2,
  output logic [AW-1:0] mem_addr3,
  output logic [DW-1:0] mem_data0,
  output logic [DW-1:0] mem_data1,
  output logic [DW-1:0] mem_data2,
  output logic [DW-1:0] mem_data3,
  input  logic          mem_ready0,
  input  logic          mem_ready1,
  input  logic          mem_ready2,
  input  logic          mem_ready3,
  output logic          busy,
  output logic          store_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + DW;

  logic [AW-1:0] addr_in [4];
  logic [DW-1:0] data_in [4];
  logic [3:0]    ready_in;

  assign addr_in[0] = in_addr0;
  assign addr_in[1] = in_addr1;
  assign addr_in[2] = in_addr2;
  assign addr_in[3] = in_addr3;
  assign data_in[0] = in_data0;
  assign data_in[1] = in_data1;
  assign data_in[2] = in_data2;
  assign data_in[3] = in_data3;
  assign ready_in   = {mem_ready3, mem_ready2, mem_ready1, mem_ready0};

  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [PW-1:0] wr_ptr_q [4];
  logic [PW-1:0] wr_ptr_d [4];
  logic [PW-1:0] rd_ptr_q [4];
  logic [PW-1:0] rd_ptr_d [4];
  logic [EW-1:0] ent_q [4][DEPTH];
  logic [EW-1:0] ent_d [4][DEPTH];
  logic          last_pending_q;
  logic          last_pending_d;

  logic [3:0] nonempty;
  logic [3:0] push;
  logic [3:0] pop;
  logic       all_empty;
  logic       any_full;
  logic       accept;

  always_comb begin
    nonempty  = '0;
    all_empty = 1'b1;
    any_full  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nonempty[k] = (cnt_q[k] != '0);
      if (nonempty[k]) all_empty = 1'b0;
      if (cnt_q[k] == CW'(DEPTH)) any_full = 1'b1;
    end
  end

  // Readiness uses registered counts only, so a same-cycle pop never frees a slot.
  assign in_ready   = !rst && !last_pending_q && !any_full;
  assign accept     = in_valid && in_ready;
  assign store_done = !rst && last_pending_q && all_empty;
  assign busy       = last_pending_q || !all_empty;

  always_comb begin
    push = '0;
    pop  = '0;
    for (int k = 0; k < 4; k++) begin
      push[k]     = accept && in_we[k];
      pop[k]      = nonempty[k] && ready_in[k];
      cnt_d[k]    = cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
      wr_ptr_d[k] = wr_ptr_q[k] + PW'(push[k]);
      rd_ptr_d[k] = rd_ptr_q[k] + PW'(pop[k]);
      ent_d[k]    = ent_q[k];
      if (push[k]) ent_d[k][wr_ptr_q[k]] = {addr_in[k], data_in[k]};
    end

    last_pending_d = last_pending_q;
    if (store_done) last_pending_d = 1'b0;
    if (accept && in_last) last_pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k]    <= '0;
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
      end
      last_pending_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      last_pending_q <= last_pending_d;
    end
  end

  // Entry storage needs no reset: zeroed counts make stale entries unreachable.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign mem_we0 = nonempty[0];
  assign mem_we1 = nonempty[1];
  assign mem_we2 = nonempty[2];
  assign mem_we3 = nonempty[3];
  assign {mem_addr0, mem_data0} = ent_q[0][rd_ptr_q[0]];
  assign {mem_addr1, mem_data1} = ent_q[1][rd_ptr_q[1]];
  assign {mem_addr2, mem_data2} = ent_q[2][rd_ptr_q[2]];
  assign {mem_addr3, mem_data3} = ent_q[3][rd_ptr_q[3]];

  for (genvar g = 0; g < 4; g++) begin : g_chk
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      (cnt_q[g] <= CW'(DEPTH)) && !(push[g] && !pop[g] && cnt_q[g] == CW'(DEPTH)));
    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
      !(pop[g] && cnt_q[g] == '0));
  end

endmodule

// File: tb/tb_v_store_drain.sv
// Randomized and directed bench for v_store_drain against a queue-based reference model.
module tb_v_store_drain;

  localparam int DEPTH = 4;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int EW    = AW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_we;
  logic          in_last;
  logic [AW-1:0] in_addr0, in_addr1, in_addr2, in_addr3;
  logic [DW-1:0] in_data0, in_data1, in_data2, in_data3;
  logic          mem_we0, mem_we1, mem_we2, mem_we3;
  logic [AW-1:0] mem_addr0, mem_addr1, mem_addr2, mem_addr3;
  logic [DW-1:0] mem_data0, mem_data1, mem_data2, mem_data3;
  logic          mem_ready0, mem_ready1, mem_ready2, mem_ready3;
  logic          busy;
  logic          store_done;

  always #5 clk = ~clk;

  v_store_drain #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_we(in_we), .in_last(in_last),
    .in_addr0(in_addr0), .in_addr1(in_addr1), .in_addr2(in_addr2), .in_addr3(in_addr3),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .mem_we0(mem_we0), .mem_we1(mem_we1), .mem_we2(mem_we2), .mem_we3(mem_we3),
    .mem_addr0(mem_addr0), .mem_addr1(mem_addr1), .mem_addr2(mem_addr2), .mem_addr3(mem_addr3),
    .mem_data0(mem_data0), .mem_data1(mem_data1), .mem_data2(mem_data2), .mem_data3(mem_data3),
    .mem_ready0(mem_ready0), .mem_ready1(mem_ready1), .mem_ready2(mem_ready2), .mem_ready3(mem_ready3),
    .busy(busy), .store_done(store_done)
  );

  logic [3:0]    o_we;
  logic [EW-1:0] o_ent [4];
  assign o_we     = {mem_we3, mem_we2, mem_we1, mem_we0};
  assign o_ent[0] = {mem_addr0, mem_data0};
  assign o_ent[1] = {mem_addr1, mem_data1};
  assign o_ent[2] = {mem_addr2, mem_data2};
  assign o_ent[3] = {mem_addr3, mem_data3};

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stimulus for the next cycle.
  bit            s_rst;
  bit            s_valid;
  bit [3:0]      s_we;
  bit            s_last;
  bit [3:0]      s_rdy;
  bit [AW-1:0]   s_addr [4];
  bit [DW-1:0]   s_data [4];

  // Reference model: one queue per bank plus the pending-completion flag.
  logic [EW-1:0] mq [4][$];
  bit            m_lp;
  bit            m_acc;
  int            n_done;

  task automatic step();
    bit all_e, any_f, m_ready, m_done;
    @(negedge clk);
    rst      = s_rst;
    in_valid = s_valid;
    in_we    = s_we;
    in_last  = s_last;
    in_addr0 = s_addr[0]; in_addr1 = s_addr[1]; in_addr2 = s_addr[2]; in_addr3 = s_addr[3];
    in_data0 = s_data[0]; in_data1 = s_data[1]; in_data2 = s_data[2]; in_data3 = s_data[3];
    {mem_ready3, mem_ready2, mem_ready1, mem_ready0} = s_rdy;
    #1;
    all_e = 1'b1;
    any_f = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (mq[k].size() != 0) all_e = 1'b0;
      if (mq[k].size() >= DEPTH) any_f = 1'b1;
    end
    m_ready = !s_rst && !m_lp && !any_f;
    m_done  = !s_rst && m_lp && all_e;
    check("in_ready", in_ready, m_ready);
    check("store_done", store_done, m_done);
    check("busy", busy, m_lp || !all_e);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("mem_we%0d", k), o_we[k], mq[k].size() != 0);
      if (mq[k].size() != 0) check($sformatf("mem_head%0d", k), o_ent[k], mq[k][0]);
    end
    m_acc = s_valid && m_ready;
    if (s_rst) begin
      for (int k = 0; k < 4; k++) mq[k].delete();
      m_lp = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (mq[k].size() != 0 && s_rdy[k]) void'(mq[k].pop_front());
        if (m_acc && s_we[k]) mq[k].push_back({s_addr[k], s_data[k]});
      end
      if (m_done) begin
        m_lp = 1'b0;
        n_done++;
      end
      if (m_acc && s_last) m_lp = 1'b1;
    end
  endtask

  task automatic set_group(int base);
    for (int k = 0; k < 4; k++) begin
      s_addr[k] = AW'(base + k);
      s_data[k] = DW'((base + k) * 32'h1111_1111);
    end
  endtask

  task automatic idle(int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    int acc_cnt, iter, done0;
    s_rst = 1'b1; s_valid = 1'b0; s_we = '0; s_last = 1'b0; s_rdy = 4'hF;
    set_group(0);
    m_lp = 1'b0; n_done = 0;
    rst = 1'b1; in_valid = 1'b0; in_we = '0; in_last = 1'b0;
    in_addr0 = '0; in_addr1 = '0; in_addr2 = '0; in_addr3 = '0;
    in_data0 = '0; in_data1 = '0; in_data2 = '0; in_data3 = '0;
    {mem_ready3, mem_ready2, mem_ready1, mem_ready0} = 4'hF;
    @(posedge clk);
    step();
    s_rst = 1'b0;
    step();

    // Single full group with last.
    done0 = n_done;
    set_group(0); s_we = 4'hF; s_valid = 1'b1; s_last = 1'b1;
    step();
    idle(5);
    check("t1_done_count", 64'(n_done - done0), 64'd1);

    // Two-group stream, last on the second.
    done0 = n_done;
    set_group(0); s_we = 4'hF; s_valid = 1'b1; s_last = 1'b0;
    step();
    set_group(4); s_last = 1'b1;
    step();
    idle(5);
    check("t2_done_count", 64'(n_done - done0), 64'd1);

    // Bank 2 stalled while five groups are offered; release part-way.
    done0 = n_done; acc_cnt = 0; iter = 0;
    s_rdy = 4'b1011; s_we = 4'hF; s_valid = 1'b1;
    set_group(8 * acc_cnt);
    while (acc_cnt < 5 && iter < 40) begin
      s_last = (acc_cnt == 4);
      if (iter == 8) s_rdy = 4'hF;
      step();
      iter++;
      if (m_acc) begin
        acc_cnt++;
        set_group(8 * acc_cnt);
      end
    end
    check("t3_accepted", 64'(acc_cnt), 64'd5);
    s_rdy = 4'hF;
    idle(10);
    check("t3_done_count", 64'(n_done - done0), 64'd1);

    // Sparse strided enables.
    done0 = n_done;
    set_group(40); s_we = 4'b0101; s_valid = 1'b1; s_last = 1'b0;
    step();
    set_group(44); s_we = 4'b1010; s_last = 1'b1;
    step();
    idle(5);
    check("t4_done_count", 64'(n_done - done0), 64'd1);

    // Reset with three entries queued and completion pending.
    done0 = n_done;
    s_rdy = 4'h0; set_group(50); s_we = 4'b0111; s_valid = 1'b1; s_last = 1'b1;
    step();
    idle(2);
    s_rst = 1'b1;
    step();
    s_rst = 1'b0; s_rdy = 4'hF;
    idle(2);
    check("t5_no_done", 64'(n_done - done0), 64'd0);
    set_group(60); s_we = 4'hF; s_valid = 1'b1; s_last = 1'b1;
    step();
    idle(5);
    check("t5_fresh_done", 64'(n_done - done0), 64'd1);

    // Empty last group while idle.
    done0 = n_done;
    s_we = 4'h0; s_valid = 1'b1; s_last = 1'b1;
    step();
    idle(1);
    check("t6_done_next", 64'(n_done - done0), 64'd1);
    idle(3);

    // Random traffic with random per-bank backpressure and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      s_rst   = ($urandom_range(0, 299) == 0);
      s_valid = $urandom_range(0, 1) == 1;
      s_we    = 4'($urandom);
      s_last  = ($urandom_range(0, 7) == 0);
      s_rdy   = 4'($urandom);
      for (int k = 0; k < 4; k++) begin
        s_addr[k] = AW'($urandom);
        s_data[k] = DW'($urandom);
      end
      step();
    end
    s_rst = 1'b0; s_rdy = 4'hF;
    idle(12);
    check("final_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
